// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared types, byte-range constants and helpers for the MIDI receiver
package midi_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    localparam logic [7:0] STATUS_MIN  = 8'h80;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Program change (Cn) and channel pressure (Dn) carry one data byte; all others two.
    function automatic logic [1:0] data_len(input logic [7:0] status);
        return (status[7:4] == 4'hC || status[7:4] == 4'hD) ? 2'd1 : 2'd2;
    endfunction

    function automatic logic majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - oversampling serial byte receiver with majority-voted bits
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 31250,
    parameter int OSR    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       line_in,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * OSR);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW = $clog2(OSR);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PH_LO     = PW'(OSR / 2 - 1);
    localparam logic [PW-1:0] PH_MID    = PW'(OSR / 2);
    localparam logic [PW-1:0] PH_HI     = PW'(OSR / 2 + 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(OSR - 1);

    generate
        if (CLK_HZ % (BAUD * OSR) != 0) begin : g_bad_ratio
            $error("midi_uart_rx: CLK_HZ must be an integer multiple of BAUD*OSR");
        end
    endgenerate

    logic            sync1;
    logic            sync2;
    logic            armed;
    logic [TW-1:0]   tick_cnt;
    logic [PW-1:0]   phase;
    logic            s_lo;
    logic            s_mid;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    rx_state_t       state;
    logic            tick;
    logic            decide;
    logic            vote;

    assign tick   = (tick_cnt == TICK_LAST);
    assign decide = tick && (phase == PH_HI);
    assign vote   = majority(s_lo, s_mid, sync2);

    // Strobes come straight off the decision cycle; the assembler registers them.
    assign rx_byte    = shreg;
    assign byte_valid = en && (state == RX_STOP) && decide && vote;
    assign frame_err  = en && (state == RX_STOP) && decide && !vote;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            armed    <= 1'b0;
            tick_cnt <= '0;
            phase    <= '0;
            s_lo     <= 1'b1;
            s_mid    <= 1'b1;
            bit_idx  <= '0;
            shreg    <= '0;
            state    <= RX_IDLE;
        end else begin
            sync1    <= line_in;
            sync2    <= sync1;
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            armed    <= 1'b0;
            if (tick) begin
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end
            if (tick && phase == PH_LO) begin
                s_lo <= sync2;
            end
            if (tick && phase == PH_MID) begin
                s_mid <= sync2;
            end

            if (!en) begin
                state <= RX_IDLE;
            end else begin
                case (state)
                    // Only a high-to-low transition starts a frame, never a line already low.
                    RX_IDLE: begin
                        armed <= sync2;
                        if (armed && !sync2) begin
                            tick_cnt <= '0;
                            phase    <= '0;
                            state    <= RX_START;
                        end
                    end
                    RX_START: begin
                        bit_idx <= '0;
                        if (decide) begin
                            state <= vote ? RX_IDLE : RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (decide) begin
                            shreg   <= {vote, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= RX_STOP;
                            end
                        end
                    end
                    RX_STOP: begin
                        if (decide) begin
                            state <= vote ? RX_IDLE : RX_BREAK;
                        end
                    end
                    RX_BREAK: begin
                        if (sync2) begin
                            state <= RX_IDLE;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/midi_msg_rx.sv
// rtl/midi_msg_rx.sv - MIDI input front end: byte receiver plus running-status message assembler
module midi_msg_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 31250,
    parameter int OSR    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_en,
    input  logic       io_midi_in,
    output logic       io_msg_valid,
    output logic [7:0] io_msg_status,
    output logic [6:0] io_msg_data1,
    output logic [6:0] io_msg_data2,
    output logic       io_rt_valid,
    output logic [7:0] io_rt_byte,
    output logic       io_frame_err
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       frame_err;
    logic [7:0] running_status;
    logic       data_idx;
    logic [6:0] data1_lat;

    midi_uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OSR    (OSR)
    ) u_uart (
        .clock      (clock),
        .reset      (reset),
        .en         (io_en),
        .line_in    (io_midi_in),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_msg_valid   <= 1'b0;
            io_msg_status  <= '0;
            io_msg_data1   <= '0;
            io_msg_data2   <= '0;
            io_rt_valid    <= 1'b0;
            io_rt_byte     <= '0;
            io_frame_err   <= 1'b0;
            running_status <= '0;
            data_idx       <= 1'b0;
            data1_lat      <= '0;
        end else begin
            io_msg_valid <= 1'b0;
            io_rt_valid  <= 1'b0;
            io_frame_err <= frame_err;

            if (!io_en) begin
                running_status <= '0;
                data_idx       <= 1'b0;
            end else if (byte_valid) begin
                if (rx_byte >= RT_MIN) begin
                    // Real-time bytes interleave anywhere without touching assembly.
                    io_rt_valid <= 1'b1;
                    io_rt_byte  <= rx_byte;
                end else if (rx_byte >= SYSEX_START) begin
                    // With no running status, sysex payload bytes fall through as discards.
                    running_status <= '0;
                    data_idx       <= 1'b0;
                end else if (rx_byte >= STATUS_MIN) begin
                    running_status <= rx_byte;
                    data_idx       <= 1'b0;
                end else if (running_status != 8'h00) begin
                    if (!data_idx && data_len(running_status) == 2'd2) begin
                        data1_lat <= rx_byte[6:0];
                        data_idx  <= 1'b1;
                    end else begin
                        io_msg_valid  <= 1'b1;
                        io_msg_status <= running_status;
                        io_msg_data1  <= data_idx ? data1_lat : rx_byte[6:0];
                        io_msg_data2  <= data_idx ? rx_byte[6:0] : 7'd0;
                        data_idx      <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_msg_rx.sv
// tb/tb_midi_msg_rx.sv - directed self-checking bench for midi_msg_rx
module tb_midi_msg_rx;

    localparam int BIT = 64;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       io_en = 1'b1;
    logic       io_midi_in = 1'b1;
    logic       io_msg_valid;
    logic [7:0] io_msg_status;
    logic [6:0] io_msg_data1;
    logic [6:0] io_msg_data2;
    logic       io_rt_valid;
    logic [7:0] io_rt_byte;
    logic       io_frame_err;

    int checks = 0;
    int failures = 0;
    int msg_cnt = 0;
    int rt_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;

    midi_msg_rx #(
        .CLK_HZ (2_000_000),
        .BAUD   (31250),
        .OSR    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .io_en         (io_en),
        .io_midi_in    (io_midi_in),
        .io_msg_valid  (io_msg_valid),
        .io_msg_status (io_msg_status),
        .io_msg_data1  (io_msg_data1),
        .io_msg_data2  (io_msg_data2),
        .io_rt_valid   (io_rt_valid),
        .io_rt_byte    (io_rt_byte),
        .io_frame_err  (io_frame_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (io_msg_valid) msg_cnt++;
        if (io_rt_valid) rt_cnt++;
        if (io_frame_err) ferr_cnt++;
        if (io_msg_valid && io_rt_valid) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        io_midi_in = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            io_midi_in = v[i];
            repeat (BIT) @(negedge clock);
        end
        io_midi_in = stop_bit;
        repeat (BIT) @(negedge clock);
        io_midi_in = 1'b1;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic check_msg(input string tag, input int cnt, input logic [7:0] st,
                             input logic [6:0] d1, input logic [6:0] d2);
        check({tag, "_cnt"}, msg_cnt, cnt);
        check({tag, "_status"}, {24'd0, io_msg_status}, {24'd0, st});
        check({tag, "_data1"}, {25'd0, io_msg_data1}, {25'd0, d1});
        check({tag, "_data2"}, {25'd0, io_msg_data2}, {25'd0, d2});
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"},
              {io_msg_valid, io_msg_status, io_msg_data1, io_msg_data2,
               io_rt_valid, io_rt_byte, io_frame_err}, 32'd0);
    endtask

    initial begin
        logic [7:0] pb;
        repeat (4) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        repeat (BIT) @(negedge clock);

        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        check_msg("note_on", 1, 8'h90, 7'h3C, 7'h64);

        send_byte(8'h3E, 1'b1);
        send_byte(8'h00, 1'b1);
        check_msg("running", 2, 8'h90, 7'h3E, 7'h00);

        send_byte(8'hC5, 1'b1);
        send_byte(8'h07, 1'b1);
        check_msg("prog_chg", 3, 8'hC5, 7'h07, 7'h00);

        send_byte(8'h90, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'hF8, 1'b1);
        check("rt_cnt", rt_cnt, 1);
        check("rt_byte", {24'd0, io_rt_byte}, 32'hF8);
        check("rt_no_msg", msg_cnt, 3);
        send_byte(8'h7F, 1'b1);
        check_msg("rt_interleave", 4, 8'h90, 7'h40, 7'h7F);

        send_byte(8'h90, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h55, 1'b0);
        check("ferr_cnt", ferr_cnt, 1);
        check("ferr_no_msg", msg_cnt, 4);
        send_byte(8'h22, 1'b1);
        check_msg("ferr_idx_kept", 5, 8'h90, 7'h41, 7'h22);
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        check_msg("after_ferr", 6, 8'h90, 7'h3C, 7'h64);

        io_midi_in = 1'b0;
        repeat (5) @(negedge clock);
        io_midi_in = 1'b1;
        repeat (2000) @(negedge clock);
        check("glitch_strobes", msg_cnt + rt_cnt + ferr_cnt, 8);

        pb = 8'hFA;
        io_midi_in = 1'b0;
        repeat (BIT) @(negedge clock);
        io_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io_midi_in = pb[i];
            repeat (BIT) @(negedge clock);
        end
        io_midi_in = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        io_en = 1'b1;
        repeat (BIT) @(negedge clock);
        check("en_rt_cnt", rt_cnt, 1);
        check("en_rt_held", {24'd0, io_rt_byte}, 32'hF8);
        check("en_msg_held", {24'd0, io_msg_status}, 32'h90);

        pb = 8'h95;
        io_midi_in = 1'b0;
        repeat (BIT) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            io_midi_in = pb[i];
            repeat (BIT) @(negedge clock);
        end
        reset = 1'b1;
        io_midi_in = 1'b1;
        repeat (2) @(negedge clock);
        check_zero("mid_reset");
        reset = 1'b0;
        repeat (4 * BIT) @(negedge clock);
        check("mid_reset_strobes", msg_cnt + rt_cnt + ferr_cnt, 8);
        send_byte(8'h80, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h00, 1'b1);
        check_msg("note_off", 7, 8'h80, 7'h3C, 7'h00);

        check("msg_rt_same_cycle", both_cnt, 0);
        check("ferr_total", ferr_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
